// File: rtl/cmp_arb_pkg.sv
// Shared types and constants for the round-robin signed-compare arbiter.
package cmp_arb_pkg;

  localparam int unsigned DEF_NREQ  = 4;
  localparam int unsigned DEF_WIDTH = 4;

  // Bit positions inside the registered result flag vector
  localparam int unsigned FLAG_GT = 0;
  localparam int unsigned FLAG_EQ = 1;
  localparam int unsigned FLAG_LT = 2;
  localparam int unsigned FLAG_W  = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    RESPOND = 2'd2
  } state_t;

endpackage

// File: rtl/cmp_arbiter_if.sv
// Requester-side bus of cmp_arbiter; CMP_ARB_STATS_EN adds op_count/last_id.
interface cmp_arbiter_if import cmp_arb_pkg::*; #(
  parameter int unsigned NREQ  = DEF_NREQ,
  parameter int unsigned WIDTH = DEF_WIDTH
) ();

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] a_in;
  logic [NREQ*WIDTH-1:0] b_in;
  logic [NREQ-1:0]       grant;
  logic                  busy;
  logic                  done;
  logic                  AgtB;
  logic                  AeqB;
  logic                  AltB;
`ifdef CMP_ARB_STATS_EN
  logic [15:0]               op_count;
  logic [$clog2(NREQ)-1:0]   last_id;

  modport master (output req, a_in, b_in,
                  input  grant, busy, done, AgtB, AeqB, AltB, op_count, last_id);
  modport slave  (input  req, a_in, b_in,
                  output grant, busy, done, AgtB, AeqB, AltB, op_count, last_id);
`else
  modport master (output req, a_in, b_in,
                  input  grant, busy, done, AgtB, AeqB, AltB);
  modport slave  (input  req, a_in, b_in,
                  output grant, busy, done, AgtB, AeqB, AltB);
`endif

endinterface

// File: rtl/signed_cmp.sv
// Combinational two's-complement comparator: sign bits decide first, else unsigned compare.
module signed_cmp #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  always_comb begin
    eq = (a == b);
    gt = 1'b0;
    lt = 1'b0;
    if (a[WIDTH-1] && !b[WIDTH-1]) begin
      lt = 1'b1;
    end else if (!a[WIDTH-1] && b[WIDTH-1]) begin
      gt = 1'b1;
    end else begin
      gt = (a > b);
      lt = (a < b);
    end
  end

endmodule

// File: rtl/cmp_arbiter.sv
// Round-robin arbiter sharing one signed comparator among NREQ requesters.
// Optional statistics outputs enabled by CMP_ARB_STATS_EN.
module cmp_arbiter import cmp_arb_pkg::*; #(
  parameter int unsigned NREQ  = DEF_NREQ,
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input logic          clk,
  input logic          rst,
  cmp_arbiter_if.slave bus
);

  localparam int unsigned PW = $clog2(NREQ);
  localparam int unsigned CW = PW + 1;

  state_t            state, state_n;
  logic [NREQ-1:0]   grant, grant_n;
  logic              busy, busy_n;
  logic              done, done_n;
  logic [FLAG_W-1:0] flags, flags_n;
  logic [WIDTH-1:0]  op_a, op_a_n;
  logic [WIDTH-1:0]  op_b, op_b_n;
  logic [PW-1:0]     ptr, ptr_n;
  logic [PW-1:0]     win, win_n;

  logic [WIDTH-1:0]  a_arr [NREQ];
  logic [WIDTH-1:0]  b_arr [NREQ];
  logic              found;
  logic [CW-1:0]     cand;
  logic [PW-1:0]     sel;
  logic              cmp_gt, cmp_eq, cmp_lt;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign a_arr[i] = bus.a_in[i*WIDTH +: WIDTH];
    assign b_arr[i] = bus.b_in[i*WIDTH +: WIDTH];
  end

  signed_cmp #(.WIDTH(WIDTH)) u_cmp (
    .a  (op_a),
    .b  (op_b),
    .gt (cmp_gt),
    .eq (cmp_eq),
    .lt (cmp_lt)
  );

  // First pending request at or after the pointer, wrapping modulo NREQ
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = CW'(ptr) + CW'(i);
      if (cand >= CW'(NREQ)) cand = cand - CW'(NREQ);
      if (!found && bus.req[cand[PW-1:0]]) begin
        found = 1'b1;
        sel   = cand[PW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      flags <= '0;
      op_a  <= '0;
      op_b  <= '0;
      ptr   <= '0;
      win   <= '0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      busy  <= busy_n;
      done  <= done_n;
      flags <= flags_n;
      op_a  <= op_a_n;
      op_b  <= op_b_n;
      ptr   <= ptr_n;
      win   <= win_n;
    end
  end

  always_comb begin
    state_n = state;
    grant_n = grant;
    busy_n  = busy;
    done_n  = 1'b0;
    flags_n = flags;
    op_a_n  = op_a;
    op_b_n  = op_b;
    ptr_n   = ptr;
    win_n   = win;
    case (state)
      IDLE: begin
        grant_n = '0;
        busy_n  = 1'b0;
        if (found) begin
          state_n      = COMPARE;
          grant_n[sel] = 1'b1;
          busy_n       = 1'b1;
          op_a_n       = a_arr[sel];
          op_b_n       = b_arr[sel];
          win_n        = sel;
        end
      end
      COMPARE: begin
        flags_n          = '0;
        flags_n[FLAG_GT] = cmp_gt;
        flags_n[FLAG_EQ] = cmp_eq;
        flags_n[FLAG_LT] = cmp_lt;
        done_n           = 1'b1;
        state_n          = RESPOND;
      end
      RESPOND: begin
        state_n = IDLE;
        grant_n = '0;
        busy_n  = 1'b0;
        ptr_n   = (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
        busy_n  = 1'b0;
      end
    endcase
  end

  assign bus.grant = grant;
  assign bus.busy  = busy;
  assign bus.done  = done;
  assign bus.AgtB  = flags[FLAG_GT];
  assign bus.AeqB  = flags[FLAG_EQ];
  assign bus.AltB  = flags[FLAG_LT];

`ifdef CMP_ARB_STATS_EN
  logic [15:0]   op_count;
  logic [PW-1:0] last_id;

  // Counts results as their done pulse is launched; saturates
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count <= '0;
      last_id  <= '0;
    end else if (done_n) begin
      if (op_count != 16'hFFFF) op_count <= op_count + 16'd1;
      last_id <= win;
    end
  end

  assign bus.op_count = op_count;
  assign bus.last_id  = last_id;
`endif

endmodule

// File: doc/cmp_arbiter.md
Name: cmp_arbiter

Overview:
- Shares one signed two's-complement magnitude comparator among NREQ requesters.
- Round-robin arbitration, latched operands, registered AgtB/AeqB/AltB flags, one-cycle done pulse per served request.
- Sits between the combinational compare datapath and the control units that need signed compares (branch resolution, sorting).

Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 4, operand width in bits, two's complement

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, synchronous, active-high
- req  in  NREQ  per-requester request; held high with operands stable until done for that requester
- a_in  in  NREQ*WIDTH  operand A, requester i in bits [i*WIDTH +: WIDTH]
- b_in  in  NREQ*WIDTH  operand B, same packing
- grant  out  NREQ  one-hot; identifies the requester being served, valid from LATCH through RESPOND
- busy  out  1  high in COMPARE and RESPOND
- done  out  1  one-cycle pulse, result valid
- AgtB  out  1  signed A > B, valid with done
- AeqB  out  1  A == B, valid with done
- AltB  out  1  signed A < B, valid with done

Behaviour:
- Reset values:
  - grant=0, busy=0, done=0, AgtB=AeqB=AltB=0.
  - State=IDLE; round-robin pointer=0, so requester 0 has highest priority.
- FSM states are IDLE, COMPARE and RESPOND.
- IDLE:
  - If req != 0, select the first set req bit at or after the pointer (wrapping NREQ-1 to 0).
  - Latch that requester's a/b into op_a/op_b, set grant one-hot, go to COMPARE.
  - Else stay in IDLE with grant=0.
- COMPARE:
  - Sub-module evaluates op_a/op_b combinationally.
  - Flags registered at the end of the cycle; go to RESPOND.
- RESPOND:
  - done=1 for exactly one cycle, flags held, grant held.
  - Pointer set to winner+1 mod NREQ; go to IDLE.
- Latency and throughput:
  - req sampled in IDLE at edge t; done high during cycle t+2.
  - Peak throughput is one compare per 3 cycles.
- Flags:
  - Exactly one of AgtB/AeqB/AltB is high when done=1.
  - Flags keep their last value after done falls; they are cleared only by reset.
- Signed rules:
  - If sign(A)=1 and sign(B)=0, AltB.
  - If sign(A)=0 and sign(B)=1, AgtB.
  - If the signs are equal, compare unsigned.
  - Full WIDTH range applies, e.g. -8 vs 7 at WIDTH=4.
- Boundary conditions:
  - req dropped after latch: the operation completes on latched operands and done still pulses.
  - Operand change after latch: ignored.
  - Requester keeps req high after its done: treated as a new request. It loses priority to any other pending requester because of the pointer advance.
  - All NREQ requesting continuously: served in order p, p+1, … with no starvation; max wait is 3*(NREQ-1) cycles.
  - rst asserted in any state: next cycle is IDLE with all outputs at reset values; the in-flight result is discarded (no done).
  - Single requester: served back-to-back every 3 cycles.

Optional Feature:
- Macro: CMP_ARB_STATS_EN.
- When defined:
  - Adds output op_count[15:0], which increments on each done pulse and saturates at 16'hFFFF.
  - Adds output last_id[$clog2(NREQ)-1:0], the binary index of the last served requester.
  - Both reset to 0.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package cmp_arb_pkg:
  - FSM state enum (IDLE, COMPARE, RESPOND).
  - Default WIDTH/NREQ constants.
  - Result flag index constants (GT=0, EQ=1, LT=2).
- One sub-module, signed_cmp:
  - Purely combinational, parameter WIDTH.
  - Inputs a and b; outputs gt, eq and lt.
  - Implements the signed rules above.
  - Instantiated once on op_a/op_b.

Test Plan:
- Reset then req=4'b0001, a0=-8 (4'b1000), b0=-5 (4'b1011) -> grant=0001 from t+1, done at t+2 with AltB=1, AgtB=AeqB=0.
- req=4'b0010, a1=5, b1=-1 (4'b1111) -> done at t+2, AgtB=1; a1=2, b1=7 -> AltB=1; a1=b1=-3 -> AeqB=1.
- req=4'b1111 held for 12 cycles -> grants in order 0001, 0010, 0100, 1000, one done every 3 cycles, pointer wraps to 0001.
- req=4'b0001 asserted then dropped one cycle after grant; a0 changed to 7 after latch -> done still pulses with the latched-operand result.
- rst pulsed during COMPARE -> next cycle busy=0, grant=0, no done; pointer=0, so a subsequent req=4'b1010 grants 0010 first.
- With CMP_ARB_STATS_EN: 5 served requests -> op_count=5, last_id equals the index of the last grant; without the macro the bench compiles without these ports.
